ro_freq_meter: RTL and testbench

Parametrised multi-channel ring-oscillator frequency meter, the next-generation measurement core of the temperature sensor. It counts rising edges of N_CH asynchronous (prescaled) RO inputs over a programmable window of system clocks. It then streams the results as a byte frame over a valid/ready interface to the UART transmitter. Supports single-shot and continuous measurement, plus per-channel saturation flags.

---
 rtl/ro_freq_meter_pkg.sv | 20 ++
 rtl/ro_freq_meter_if.sv | 12 +
 rtl/ro_edge_counter.sv | 50 +++++
 rtl/ro_freq_meter.sv | 144 ++++++++++++++
 tb/tb_ro_freq_meter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_freq_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// Holds the FSM state encoding, the frame header byte and the frame length helper.
package ro_meter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        COUNT,
        LATCH,
        SEND
    } state_t;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    // One header byte followed by every channel count split into bytes.
    function automatic int frame_len(input int n_ch, input int cnt_w);
        return 1 + n_ch * cnt_w / 8;
    endfunction

endpackage

// File: rtl/ro_freq_meter_if.sv
// Byte stream from the frequency meter to the UART transmitter.
// The meter drives data/valid; the consumer drives ready.
interface ro_freq_meter_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/ro_edge_counter.sv
// One measurement channel: synchronises an asynchronous RO input, detects
// rising edges and counts them in a saturating counter with a sticky overflow flag.
module ro_edge_counter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ro,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    assign rise = sync_q[SYNC_STAGES-1] && !prev_q;

    // prev_q is deliberately left alone by clear so a high input at window
    // start does not look like a fresh edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ro};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (enable && rise) begin
            if (count == '1) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ro_freq_meter.sv
// Multi-channel RO frequency meter: counts edges over a programmable window
// and streams header plus per-channel counts (MSB first) as a byte frame.
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [N_CH-1:0]   ro_in,
    input  logic              start,
    input  logic              continuous,
    input  logic [WIN_W-1:0]  win_len,
    output logic              busy,
    output logic              done,
    output logic [N_CH-1:0]   overflow,
    ro_freq_meter_if.master   out_if
);

    localparam int FRAME_LEN = frame_len(N_CH, CNT_W);
    localparam int IDX_W     = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t                 state, next_state;
    logic [WIN_W-1:0]       win_reg, win_cnt;
    logic [IDX_W-1:0]       byte_idx;
    logic [CNT_W-1:0]       cnt    [N_CH];
    logic [CNT_W-1:0]       result [N_CH];
    logic [N_CH-1:0]        cnt_ovf;
    logic [FRAME_LEN*8-1:0] frame_bits;
    logic [7:0]             next_byte;
    logic                   accept, last_accept;
    int                     next_pos;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ro_edge_counter #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .ro       (ro_in[g]),
            .clear    (state == ARM),
            .enable   (state == COUNT),
            .count    (cnt[g]),
            .overflow (cnt_ovf[g])
        );
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        accept      = out_if.out_valid && out_if.out_ready;
        last_accept = (state == SEND) && accept && (byte_idx == LAST_IDX);
        if (!en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = ARM;
                ARM:     next_state = COUNT;
                COUNT:   if (win_cnt == win_reg) next_state = LATCH;
                LATCH:   next_state = SEND;
                SEND:    if (last_accept) next_state = continuous ? ARM : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // The whole frame as one flat vector, header in the top byte.
    always_comb begin
        frame_bits = '0;
        frame_bits[FRAME_LEN*8-1 -: 8] = FRAME_HDR;
        for (int c = 0; c < N_CH; c++) begin
            frame_bits[(N_CH-1-c)*CNT_W +: CNT_W] = result[c];
        end
        next_pos = FRAME_LEN - 2 - int'(byte_idx);
        if (next_pos < 0) begin
            next_pos = 0;
        end
        next_byte = frame_bits[next_pos*8 +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_reg          <= '0;
            win_cnt          <= '0;
            byte_idx         <= '0;
            overflow         <= '0;
            done             <= 1'b0;
            out_if.out_data  <= 8'h00;
            out_if.out_valid <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                result[c] <= '0;
            end
        end else begin
            done <= en && last_accept;
            if (!en) begin
                out_if.out_valid <= 1'b0;
            end else begin
                case (state)
                    ARM: begin
                        win_reg <= (win_len == '0) ? WIN_W'(1) : win_len;
                        win_cnt <= WIN_W'(1);
                    end
                    COUNT: win_cnt <= win_cnt + WIN_W'(1);
                    LATCH: begin
                        for (int c = 0; c < N_CH; c++) begin
                            result[c] <= cnt[c];
                        end
                        overflow         <= cnt_ovf;
                        byte_idx         <= '0;
                        out_if.out_data  <= FRAME_HDR;
                        out_if.out_valid <= 1'b1;
                    end
                    SEND: begin
                        if (accept) begin
                            if (byte_idx == LAST_IDX) begin
                                out_if.out_valid <= 1'b0;
                            end else begin
                                byte_idx        <= byte_idx + IDX_W'(1);
                                out_if.out_data <= next_byte;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Scoreboard bench for ro_freq_meter: directed frames are queued as expected
// bytes and a negedge monitor checks every accepted byte against the queue.
module tb_ro_freq_meter;
    import ro_meter_pkg::*;

    logic        clk = 1'b0;
    logic        reset, en, start, start8, continuous;
    logic [15:0] win_len;
    logic [3:0]  ro_in, ro8;
    logic        busy, done, busy8, done8;
    logic [3:0]  overflow, overflow8;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0, done8_cnt = 0, valid_seen = 0;
    int period[4]  = '{default: 0};
    int period8[4] = '{default: 0};
    logic [7:0] exp_q[$];
    logic [7:0] exp8_q[$];

    always #5 clk = ~clk;

    ro_freq_meter_if bus ();
    ro_freq_meter_if bus8 ();

    ro_freq_meter #(.N_CH(4), .CNT_W(16), .WIN_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .en(en), .ro_in(ro_in), .start(start),
        .continuous(continuous), .win_len(win_len), .busy(busy), .done(done),
        .overflow(overflow), .out_if(bus)
    );

    ro_freq_meter #(.N_CH(4), .CNT_W(8), .WIN_W(16), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .en(en), .ro_in(ro8), .start(start8),
        .continuous(1'b0), .win_len(win_len), .busy(busy8), .done(done8),
        .overflow(overflow8), .out_if(bus8)
    );

    function automatic void checkOutput(input string name, input int unsigned actual,
                                        input int unsigned expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endfunction

    // Periodic RO stimulus, derived from a free-running tick so it is synchronous to clk.
    initial begin
        int tick = 0;
        ro_in = '0;
        ro8   = '0;
        forever begin
            @(posedge clk);
            #2;
            tick++;
            for (int c = 0; c < 4; c++) begin
                ro_in[c] = (period[c] != 0) && ((tick % (period[c] == 0 ? 1 : period[c])) < period[c] / 2);
                ro8[c]   = (period8[c] != 0) && ((tick % (period8[c] == 0 ? 1 : period8[c])) < period8[c] / 2);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done)          done_cnt++;
                if (done8)         done8_cnt++;
                if (bus.out_valid) valid_seen++;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_byte actual=%02h required=none", bus.out_data);
                    end else begin
                        checkOutput("frame_byte", bus.out_data, exp_q.pop_front());
                    end
                end
                if (bus8.out_valid && bus8.out_ready) begin
                    if (exp8_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_byte8 actual=%02h required=none", bus8.out_data);
                    end else begin
                        checkOutput("frame8_byte", bus8.out_data, exp8_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [15:0] wl, input bit cont, input bit use8);
        win_len    = wl;
        continuous = cont;
        if (use8) start8 = 1'b1;
        else      start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 1;
        while (!bus.out_valid && cycles < 5000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!bus.out_valid) checkOutput("valid_timeout", 0, 1);
    endtask

    task automatic waitDone(input bit use8, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = use8 ? done8 : done;
        end
        if (!seen) checkOutput(use8 ? "done8_timeout" : "done_timeout", 0, 1);
    endtask

    task automatic pushFrame16(input int c0, input int c1, input int c2, input int c3);
        int c[4];
        c = '{c0, c1, c2, c3};
        exp_q.push_back(FRAME_HDR);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'(c[i] >> 8));
            exp_q.push_back(8'(c[i]));
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        int snap_valid, snap_done, high_cycles;

        reset = 1'b1; en = 1'b1; start = 1'b0; start8 = 1'b0; continuous = 1'b0;
        win_len = '0;
        bus.out_ready = 1'b1;
        bus8.out_ready = 1'b1;
        idleCycles(3);
        reset = 1'b0;
        idleCycles(1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_out_data", bus.out_data, 8'h00);
        checkOutput("reset_out_valid", bus.out_valid, 0);

        // Basic count: 10 edges of ch0 in a 100-cycle window.
        period[0] = 10;
        idleCycles(20);
        pushFrame16(10, 0, 0, 0);
        applyStimulus(16'd100, 1'b0, 1'b0);
        waitValid(n);
        checkOutput("first_valid_latency", n, 103);
        waitDone(1'b0, 200);
        idleCycles(5);
        checkOutput("basic_done_pulses", done_cnt, 1);
        checkOutput("basic_queue_drained", exp_q.size(), 0);
        checkOutput("basic_busy_after", busy, 0);
        checkOutput("basic_overflow", overflow, 0);

        // Saturation on the 8-bit instance.
        period8[1] = 4;
        period8[2] = 2;
        idleCycles(10);
        exp8_q.push_back(8'hA5);
        exp8_q.push_back(8'h00);
        exp8_q.push_back(8'hFA);
        exp8_q.push_back(8'hFF);
        exp8_q.push_back(8'h00);
        applyStimulus(16'd1000, 1'b0, 1'b1);
        waitDone(1'b1, 2000);
        idleCycles(3);
        checkOutput("sat_overflow", overflow8, 4'b0100);
        checkOutput("sat_done_pulses", done8_cnt, 1);
        checkOutput("sat_queue_drained", exp8_q.size(), 0);

        // Backpressure: header held 20 cycles, then random ready.
        period[1] = 20;
        idleCycles(30);
        pushFrame16(10, 5, 0, 0);
        bus.out_ready = 1'b0;
        applyStimulus(16'd100, 1'b0, 1'b0);
        waitValid(n);
        for (int i = 0; i < 20; i++) begin
            checkOutput("bp_hold_data", bus.out_data, 8'hA5);
            checkOutput("bp_hold_valid", bus.out_valid, 1);
            @(posedge clk);
            #1;
        end
        n = 0;
        while (!done && n < 2000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) checkOutput("bp_done_timeout", 0, 1);
        bus.out_ready = 1'b1;
        idleCycles(3);
        checkOutput("bp_done_pulses", done_cnt, 2);
        checkOutput("bp_queue_drained", exp_q.size(), 0);

        // Continuous: two back-to-back frames, then drop continuous.
        period[1] = 25;
        idleCycles(30);
        pushFrame16(5, 2, 0, 0);
        pushFrame16(5, 2, 0, 0);
        applyStimulus(16'd50, 1'b1, 1'b0);
        waitDone(1'b0, 200);
        checkOutput("cont_rearm_busy", busy, 1);
        checkOutput("cont_rearm_valid", bus.out_valid, 0);
        waitValid(n);
        continuous = 1'b0;
        waitDone(1'b0, 200);
        checkOutput("cont_idle_busy", busy, 0);
        snap_valid = valid_seen;
        idleCycles(100);
        checkOutput("cont_no_third_frame", valid_seen, snap_valid);
        checkOutput("cont_done_pulses", done_cnt, 4);
        checkOutput("cont_queue_drained", exp_q.size(), 0);

        // Abort in the 10th COUNT cycle.
        snap_valid = valid_seen;
        snap_done  = done_cnt;
        applyStimulus(16'd100, 1'b0, 1'b0);
        idleCycles(10);
        en = 1'b0;
        idleCycles(1);
        checkOutput("abort_busy", busy, 0);
        idleCycles(150);
        checkOutput("abort_no_valid", valid_seen, snap_valid);
        checkOutput("abort_no_done", done_cnt, snap_done);
        en = 1'b1;
        idleCycles(5);
        pushFrame16(10, 4, 0, 0);
        applyStimulus(16'd100, 1'b0, 1'b0);
        waitDone(1'b0, 300);
        idleCycles(3);
        checkOutput("abort_fresh_done", done_cnt, snap_done + 1);
        checkOutput("abort_queue_drained", exp_q.size(), 0);

        // Start pulsed during SEND is ignored.
        pushFrame16(10, 4, 0, 0);
        bus.out_ready = 1'b0;
        applyStimulus(16'd100, 1'b0, 1'b0);
        waitValid(n);
        start = 1'b1;
        idleCycles(1);
        start = 1'b0;
        bus.out_ready = 1'b1;
        waitDone(1'b0, 100);
        high_cycles = 0;
        snap_valid = valid_seen;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (busy) high_cycles++;
        end
        checkOutput("send_start_ignored", high_cycles, 0);
        checkOutput("send_start_no_valid", valid_seen, snap_valid);
        checkOutput("send_queue_drained", exp_q.size(), 0);

        // Async reset in the middle of SEND.
        pushFrame16(10, 4, 0, 0);
        bus.out_ready = 1'b0;
        applyStimulus(16'd100, 1'b0, 1'b0);
        waitValid(n);
        idleCycles(3);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_data", bus.out_data, 8'h00);
        checkOutput("rst_overflow", overflow, 0);
        exp_q.delete();
        idleCycles(3);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        high_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (busy || bus.out_valid || bus.out_data != 8'h00) high_cycles++;
        end
        checkOutput("rst_stays_idle", high_cycles, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
